// File: rtl/ddr_tg_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ddr_tg_pkg
// Purpose  : Shared FSM encoding, LFSR taps and sequencing-mode constants for
//            the DDR traffic generator.
// Revision : 1.0 - initial release
// ============================================================================
package ddr_tg_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_WAIT_INIT = 3'd1;
    localparam state_t S_ISSUE     = 3'd2;
    localparam state_t S_WAIT_ACK  = 3'd3;
    localparam state_t S_WR_DATA   = 3'd4;
    localparam state_t S_RD_DATA   = 3'd5;
    localparam state_t S_WAIT_IDLE = 3'd6;
    localparam state_t S_DONE      = 3'd7;

    // x^16 + x^14 + x^13 + x^11 + 1, left-shifting Fibonacci form
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int MODE_SEQ        = 0;
    localparam int MODE_INTERLEAVE = 1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr_tg_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : ddr_tg_lfsr
// Purpose  : 16-bit pattern LFSR, loadable with SEED, sized to DATA_W.
// Revision : 1.0 - initial release
// ============================================================================
module ddr_tg_lfsr
    import ddr_tg_pkg::*;
#(
    parameter int          DATA_W = 16,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    output logic [DATA_W-1:0] value
);

    logic [15:0] r_lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= SEED;
        end else if (load) begin
            r_lfsr <= SEED;
        end else if (step) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign value = DATA_W'(r_lfsr);

endmodule
`default_nettype wire

// File: rtl/ddr_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module   : ddr_traffic_gen
// Purpose  : Writes NUM_TXN pseudo-random bursts through the controller host
//            port, reads them back and counts mismatching beats. Defining
//            DDR_TG_ERR_LOG_EN adds capture of the first mismatch.
// Revision : 1.0 - initial release
// ============================================================================
module ddr_traffic_gen
    import ddr_tg_pkg::*;
#(
    parameter int          DATA_W    = 16,
    parameter int          BURST_LEN = 4,
    parameter int          ROW_W     = 13,
    parameter int          COL_W     = 10,
    parameter int          BA_W      = 2,
    parameter int          NUM_TXN   = 8,
    parameter int          MODE      = 0,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          TIMEOUT   = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              init_done,
    input  logic              ctrl_busy,
    input  logic              wr_data_req,
    input  logic              rd_data_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic              addr_strobe_n,
    output logic              rd_wr_req,
    output logic [ROW_W-1:0]  sys_addr_row,
    output logic [COL_W-1:0]  sys_addr_col,
    output logic [BA_W-1:0]   sys_ba,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic              timeout_err
`ifdef DDR_TG_ERR_LOG_EN
    ,
    output logic [15:0]                    first_err_txn,
    output logic [$clog2(BURST_LEN):0]     first_err_beat,
    output logic [DATA_W-1:0]              first_err_exp,
    output logic [DATA_W-1:0]              first_err_act
`endif
);

    localparam int BEAT_W = $clog2(BURST_LEN) + 1;
    localparam int TO_W   = $clog2(TIMEOUT + 1);

    state_t              r_state;
    state_t              w_next;
    logic [TO_W-1:0]     r_to_cnt;
    logic [BEAT_W-1:0]   r_beat;
    logic [15:0]         r_txn;
    logic                r_is_read;
    logic [15:0]         r_err_cnt;
    logic                r_timeout;

    logic                w_start;
    logic                w_waiting;
    logic                w_timeout;
    logic                w_last_txn;
    logic                w_beat_last;
    logic                w_run_end;
    logic                w_wr_accept;
    logic                w_rd_accept;
    logic                w_mismatch;
    logic                w_advance;
    logic [DATA_W-1:0]   w_wr_val;
    logic [DATA_W-1:0]   w_exp_val;

    assign w_start     = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_waiting   = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_timeout   = w_waiting && (r_to_cnt == TO_W'(TIMEOUT - 1));
    assign w_last_txn  = (r_txn == 16'(NUM_TXN - 1));
    assign w_beat_last = (r_beat == BEAT_W'(BURST_LEN - 1));
    assign w_run_end   = r_is_read && w_last_txn;
    assign w_wr_accept = (r_state == S_WR_DATA) && wr_data_req;
    assign w_rd_accept = (r_state == S_RD_DATA) && rd_data_valid;
    assign w_mismatch  = w_rd_accept && (rd_data != w_exp_val);
    assign w_advance   = (r_state == S_WAIT_IDLE) && !ctrl_busy && !w_run_end && !w_timeout;

    ddr_tg_lfsr #(.DATA_W(DATA_W), .SEED(SEED)) u_wr_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (w_start),
        .step  (w_wr_accept),
        .value (w_wr_val)
    );

    ddr_tg_lfsr #(.DATA_W(DATA_W), .SEED(SEED)) u_exp_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (w_start),
        .step  (w_rd_accept),
        .value (w_exp_val)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_timeout) begin
            w_next = S_DONE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: if (start)         w_next = S_WAIT_INIT;
                S_WAIT_INIT:    if (init_done)     w_next = S_ISSUE;
                S_ISSUE:        if (!ctrl_busy)    w_next = S_WAIT_ACK;
                S_WAIT_ACK:     if (ctrl_busy)     w_next = r_is_read ? S_RD_DATA : S_WR_DATA;
                S_WR_DATA:      if (wr_data_req && w_beat_last)   w_next = S_WAIT_IDLE;
                S_RD_DATA:      if (rd_data_valid && w_beat_last) w_next = S_WAIT_IDLE;
                S_WAIT_IDLE:    if (!ctrl_busy)    w_next = w_run_end ? S_DONE : S_ISSUE;
                default:                           w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        addr_strobe_n = !((r_state == S_ISSUE) && !ctrl_busy && !w_timeout);
        busy          = w_waiting;
        done          = (r_state == S_DONE);
        pass          = (r_state == S_DONE) && (r_err_cnt == 16'd0) && !r_timeout;
        wr_data       = (r_state == S_WR_DATA) ? w_wr_val : '0;
    end

    assign rd_wr_req    = r_is_read;
    assign sys_addr_row = ROW_W'(r_txn);
    assign sys_addr_col = COL_W'(32'(r_txn) * 32'(BURST_LEN));
    assign sys_ba       = BA_W'(r_txn);
    assign err_count    = r_err_cnt;
    assign timeout_err  = r_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_txn     <= '0;
            r_is_read <= 1'b0;
            r_err_cnt <= '0;
            r_timeout <= 1'b0;
            r_beat    <= '0;
            r_to_cnt  <= '0;
        end else begin
            if (w_start) begin
                r_txn     <= '0;
                r_is_read <= 1'b0;
                r_err_cnt <= '0;
                r_timeout <= 1'b0;
            end else begin
                if (w_timeout) begin
                    r_timeout <= 1'b1;
                end
                if (w_mismatch && (r_err_cnt != 16'hFFFF)) begin
                    r_err_cnt <= r_err_cnt + 16'd1;
                end
                // Reads always follow write order, so both LFSRs see the same sequence
                if (w_advance) begin
                    if (MODE == MODE_INTERLEAVE) begin
                        if (r_is_read) begin
                            r_txn     <= r_txn + 16'd1;
                            r_is_read <= 1'b0;
                        end else begin
                            r_is_read <= 1'b1;
                        end
                    end else if (w_last_txn) begin
                        r_txn     <= '0;
                        r_is_read <= 1'b1;
                    end else begin
                        r_txn <= r_txn + 16'd1;
                    end
                end
            end

            if (w_next != r_state) begin
                r_beat   <= '0;
                r_to_cnt <= '0;
            end else begin
                if (w_wr_accept || w_rd_accept) begin
                    r_beat <= r_beat + BEAT_W'(1);
                end
                if (w_waiting) begin
                    r_to_cnt <= r_to_cnt + TO_W'(1);
                end
            end
        end
    end

`ifdef DDR_TG_ERR_LOG_EN
    logic r_err_seen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_seen     <= 1'b0;
            first_err_txn  <= '0;
            first_err_beat <= '0;
            first_err_exp  <= '0;
            first_err_act  <= '0;
        end else if (w_start) begin
            r_err_seen     <= 1'b0;
            first_err_txn  <= '0;
            first_err_beat <= '0;
            first_err_exp  <= '0;
            first_err_act  <= '0;
        end else if (w_mismatch && !r_err_seen) begin
            r_err_seen     <= 1'b1;
            first_err_txn  <= r_txn;
            first_err_beat <= r_beat;
            first_err_exp  <= w_exp_val;
            first_err_act  <= rd_data;
        end
    end
`endif

endmodule
`default_nettype wire
